// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris score path: FSM state,
// line-clear point values and the score width/ceiling.
package tetris_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } score_state_e;

  localparam int SCORE_W = 14;
  localparam int MAX_SCORE = 9999;

  localparam logic [SCORE_W-1:0] PTS_1 = 14'd40;
  localparam logic [SCORE_W-1:0] PTS_2 = 14'd100;
  localparam logic [SCORE_W-1:0] PTS_3 = 14'd300;
  localparam logic [SCORE_W-1:0] PTS_4 = 14'd1200;

  function automatic logic [SCORE_W-1:0] pts_of(input logic [2:0] n_lines);
    logic [SCORE_W-1:0] pts;
    case (n_lines)
      3'd1:    pts = PTS_1;
      3'd2:    pts = PTS_2;
      3'd3:    pts = PTS_3;
      3'd4:    pts = PTS_4;
      default: pts = 14'd0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/score_accumulator_sat_add14.sv
// Combinational 14-bit adder that clamps at a ceiling instead of wrapping.
module sat_add14
  import tetris_pkg::*;
#(
  parameter int MAX = MAX_SCORE
) (
  input  logic [SCORE_W-1:0] i_a,
  input  logic [SCORE_W-1:0] i_b,
  output logic [SCORE_W-1:0] o_sum
);

  logic [SCORE_W:0] w_sum15;

  assign w_sum15 = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum   = (w_sum15 > 15'(MAX)) ? 14'(MAX) : w_sum15[SCORE_W-1:0];

endmodule

// File: rtl/score_accumulator.sv
// Running score, line total and level for the score display. Line clears
// are multiplied by (level+1) through repeated saturating adds.
module score_accumulator
  import tetris_pkg::*;
#(
  parameter int MAX_SCORE_P     = MAX_SCORE,
  parameter int MAX_LINES       = 999,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               game_clr,
  input  logic               ev_valid,
  input  logic [2:0]         ev_lines,
  output logic               ev_ready,
  input  logic               drop_pulse,
  output logic [SCORE_W-1:0] count,
  output logic [3:0]         level,
  output logic [9:0]         lines_total,
  output logic               busy
);

  localparam logic [10:0] LINES_CAP = 11'(MAX_LINES);

  score_state_e       r_state;
  logic [SCORE_W-1:0] r_acc;
  logic [SCORE_W-1:0] r_base;
  logic [3:0]         r_mult_cnt;
  logic [SCORE_W-1:0] r_count;
  logic [3:0]         r_level;
  logic [9:0]         r_lines;
  logic [3:0]         r_pend;
  logic               r_busy;

  score_state_e       w_state_nxt;
  logic [SCORE_W-1:0] w_acc_nxt;
  logic [SCORE_W-1:0] w_base_nxt;
  logic [3:0]         w_mult_nxt;
  logic [SCORE_W-1:0] w_count_nxt;
  logic [3:0]         w_level_nxt;
  logic [9:0]         w_lines_nxt;
  logic [3:0]         w_pend_nxt;

  logic               w_legal;
  logic               w_accept;
  logic               w_drain;
  logic [SCORE_W-1:0] w_add_a;
  logic [SCORE_W-1:0] w_add_b;
  logic [SCORE_W-1:0] w_sum;
  logic [10:0]        w_lines_sum;
  logic [9:0]         w_lines_sat;

  function automatic logic [3:0] level_of(input logic [9:0] lines);
    logic [3:0] lvl;
    logic [9:0] thr;
    lvl = 4'd0;
    thr = 10'(LINES_PER_LEVEL);
    for (int k = 1; k <= MAX_LEVEL; k++) begin
      if (lines >= thr) lvl = 4'(k);
      else lvl = lvl;
      thr = thr + 10'(LINES_PER_LEVEL);
    end
    return lvl;
  endfunction

  assign w_legal     = (ev_lines != 3'd0) && (ev_lines <= 3'd4);
  assign w_accept    = (r_state == IDLE) && ev_valid && w_legal;
  assign w_drain     = (r_state == IDLE) && !w_accept && (r_pend != 4'd0);
  assign w_lines_sum = {1'b0, r_lines} + {8'd0, ev_lines};
  assign w_lines_sat = (w_lines_sum > LINES_CAP) ? LINES_CAP[9:0] : w_lines_sum[9:0];

  // The adder is shared: ACCUM adds the latched base, IDLE drains one drop point.
  assign w_add_a = (r_state == ACCUM) ? r_acc : r_count;
  assign w_add_b = (r_state == ACCUM) ? r_base : 14'd1;

  sat_add14 #(.MAX(MAX_SCORE_P)) u_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .o_sum (w_sum)
  );

  // Next-state and datapath update for the accept / accumulate / drain flow.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_base_nxt  = r_base;
    w_mult_nxt  = r_mult_cnt;
    w_count_nxt = r_count;
    w_level_nxt = r_level;
    w_lines_nxt = r_lines;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_base_nxt  = pts_of(ev_lines);
          w_mult_nxt  = r_level + 4'd1;
          w_acc_nxt   = r_count;
          w_lines_nxt = w_lines_sat;
          w_state_nxt = ACCUM;
        end else if (w_drain) begin
          w_count_nxt = w_sum;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        w_acc_nxt  = w_sum;
        w_mult_nxt = r_mult_cnt - 4'd1;
        if (r_mult_cnt == 4'd1) begin
          w_count_nxt = w_sum;
          w_level_nxt = level_of(r_lines);
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pending soft-drop points; a pulse arriving on a drain edge cancels the decrement.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_drain) begin
      w_pend_nxt = drop_pulse ? r_pend : (r_pend - 4'd1);
    end else if (drop_pulse && (r_pend != 4'd15)) begin
      w_pend_nxt = r_pend + 4'd1;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // State registers; new-game clear behaves like reset at lower priority.
  always_ff @(posedge CLK) begin
    if (!RST_N || game_clr) begin
      r_state    <= IDLE;
      r_acc      <= 14'd0;
      r_base     <= 14'd0;
      r_mult_cnt <= 4'd0;
      r_count    <= 14'd0;
      r_level    <= 4'd0;
      r_lines    <= 10'd0;
      r_pend     <= 4'd0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_base     <= w_base_nxt;
      r_mult_cnt <= w_mult_nxt;
      r_count    <= w_count_nxt;
      r_level    <= w_level_nxt;
      r_lines    <= w_lines_nxt;
      r_pend     <= w_pend_nxt;
      r_busy     <= (w_state_nxt == ACCUM);
    end
  end

  assign ev_ready    = (r_state == IDLE);
  assign count       = r_count;
  assign level       = r_level;
  assign lines_total = r_lines;
  assign busy        = r_busy;

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator: a table of line-clear events with
// hand-computed results plus hand-written reset, abort and drop sequences.
module tb_score_accumulator;

  logic        CLK;
  logic        RST_N;
  logic        game_clr;
  logic        ev_valid;
  logic [2:0]  ev_lines;
  logic        ev_ready;
  logic        drop_pulse;
  logic [13:0] count;
  logic [3:0]  level;
  logic [9:0]  lines_total;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] lines;
    int         exp_count;
    int         exp_lines;
    int         exp_level;
  } vec_t;

  vec_t tbl[14];

  score_accumulator dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .game_clr    (game_clr),
    .ev_valid    (ev_valid),
    .ev_lines    (ev_lines),
    .ev_ready    (ev_ready),
    .drop_pulse  (drop_pulse),
    .count       (count),
    .level       (level),
    .lines_total (lines_total),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_lines"}, 32'(lines_total), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(ev_ready), 32'd1);
  endtask

  // One-cycle event, then wait for ev_ready with a cycle budget.
  task automatic do_event(input logic [2:0] n_lines, input int exp_cycles, input int hold_count);
    int n;
    ev_valid = 1'b1;
    ev_lines = n_lines;
    tick();
    ev_valid = 1'b0;
    ev_lines = 3'd0;
    n = 0;
    while (ev_ready !== 1'b1 && n < 40) begin
      chk("hold_count", 32'(count), 32'(hold_count));
      chk("busy_high", 32'(busy), 32'd1);
      tick();
      n++;
    end
    chk("accum_cycles", 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ill[3];
    int prev_level;
    int prev_count;
    int exp_lines;
    int nl;
    int lvl;

    ill = '{3'd0, 3'd5, 3'd7};
    for (int i = 0; i < 10; i++) tbl[i] = '{3'd1, 40 * (i + 1), i + 1, (i == 9) ? 1 : 0};
    tbl[10] = '{3'd4, 2800, 14, 1};
    tbl[11] = '{3'd4, 5283, 19, 1};
    tbl[12] = '{3'd4, 7683, 23, 2};
    tbl[13] = '{3'd4, 9999, 27, 2};

    RST_N = 1'b0; game_clr = 1'b0; ev_valid = 1'b0; ev_lines = 3'd0; drop_pulse = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    RST_N = 1'b1;

    // Single line at level 0: one ACCUM cycle, count holds until commit.
    ev_valid = 1'b1; ev_lines = 3'd1;
    tick();
    ev_valid = 1'b0;
    chk("acc_ready", 32'(ev_ready), 32'd0);
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_count_hold", 32'(count), 32'd0);
    chk("acc_lines", 32'(lines_total), 32'd1);
    tick();
    chk("commit_count", 32'(count), 32'd40);
    chk("commit_ready", 32'(ev_ready), 32'd1);
    chk("commit_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 3; i++) begin
      ev_valid = 1'b1; ev_lines = ill[i];
      tick();
      ev_valid = 1'b0;
      chk("illegal_ready", 32'(ev_ready), 32'd1);
      chk("illegal_count", 32'(count), 32'd40);
      chk("illegal_lines", 32'(lines_total), 32'd1);
    end

    // Backpressure: event B held valid during A's ACCUM is taken once.
    ev_valid = 1'b1; ev_lines = 3'd1;
    tick();
    ev_lines = 3'd2;
    tick();
    chk("bp_lines_a", 32'(lines_total), 32'd2);
    chk("bp_count_a", 32'(count), 32'd80);
    tick();
    ev_valid = 1'b0;
    chk("bp_b_taken", 32'(lines_total), 32'd4);
    chk("bp_b_ready", 32'(ev_ready), 32'd0);
    tick();
    tick();
    chk("bp_count_b", 32'(count), 32'd180);
    chk("bp_once", 32'(lines_total), 32'd4);

    // Reset mid-ACCUM: no late commit.
    ev_valid = 1'b1; ev_lines = 3'd3;
    tick();
    ev_valid = 1'b0; RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    chk_zero("rst_abort");
    tick();
    chk("rst_abort_late", 32'(count), 32'd0);

    ev_valid = 1'b1; ev_lines = 3'd2;
    tick();
    ev_valid = 1'b0; game_clr = 1'b1;
    tick();
    game_clr = 1'b0;
    chk_zero("clr_abort");
    tick();
    chk("clr_abort_late", 32'(count), 32'd0);

    // 20 back-to-back drops in IDLE, drained at pace.
    drop_pulse = 1'b1;
    repeat (20) tick();
    drop_pulse = 1'b0;
    chk("drop20_mid", 32'(count), 32'd19);
    tick();
    chk("drop20_end", 32'(count), 32'd20);
    repeat (3) tick();
    chk("drop20_hold", 32'(count), 32'd20);

    // A pending drop must be discarded by game_clr.
    drop_pulse = 1'b1;
    tick();
    drop_pulse = 1'b0; game_clr = 1'b1;
    tick();
    game_clr = 1'b0;
    chk_zero("game_clr");
    repeat (2) tick();
    chk("clr_pend_gone", 32'(count), 32'd0);

    prev_level = 0;
    prev_count = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 11) begin
        // Three drops during a level-1 ACCUM, drained one per cycle afterwards.
        ev_valid = 1'b1; ev_lines = 3'd1; drop_pulse = 1'b1;
        tick();
        ev_valid = 1'b0;
        tick();
        chk("drop_accum_hold", 32'(count), 32'd2800);
        tick();
        drop_pulse = 1'b0;
        chk("drop_commit", 32'(count), 32'd2880);
        chk("drop_lines", 32'(lines_total), 32'd15);
        for (int k = 1; k <= 4; k++) begin
          tick();
          chk("drop_drain", 32'(count), 32'(2880 + ((k > 3) ? 3 : k)));
        end
        prev_count = 2883;
      end
      do_event(tbl[i].lines, prev_level + 1, prev_count);
      chk("tbl_count", 32'(count), 32'(tbl[i].exp_count));
      chk("tbl_lines", 32'(lines_total), 32'(tbl[i].exp_lines));
      chk("tbl_level", 32'(level), 32'(tbl[i].exp_level));
      prev_level = tbl[i].exp_level;
      prev_count = tbl[i].exp_count;
    end

    // Climb to MAX_LEVEL and MAX_LINES with count pinned at 9999.
    exp_lines = 27;
    for (int guard = 0; guard < 300 && exp_lines < 1000; guard++) begin
      nl = (exp_lines + 4 > 999) ? 999 : exp_lines + 4;
      lvl = (nl / 10 > 9) ? 9 : nl / 10;
      do_event(3'd4, prev_level + 1, 9999);
      chk("sat_count", 32'(count), 32'd9999);
      chk("sat_lines", 32'(lines_total), 32'(nl));
      chk("sat_level", 32'(level), 32'(lvl));
      prev_level = lvl;
      exp_lines = (exp_lines == 999) ? 1000 : nl;
    end

    drop_pulse = 1'b1;
    tick();
    drop_pulse = 1'b0;
    repeat (3) tick();
    chk("sat_drop", 32'(count), 32'd9999);

    game_clr = 1'b1;
    tick();
    game_clr = 1'b0;
    chk_zero("final_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
